// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: ID-side inputs, pipeline control, write-back and IDex outputs of the ID/EX register
interface id_ex_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              ID__Valid;
    logic [REG_W-1:0]  ID__Rs1, ID__Rs2, ID__Rdst;
    logic              ID__Need_Rs1, ID__Need_Rs2;
    logic              ID__R_WE, ID__Read_MEM, ID__Write_MEM;
    logic [1:0]        ID__RDst_S;
    logic [3:0]        ID__ALU_Op;
    logic [DATA_W-1:0] ID__Op1, ID__Op2, ID__Imm, ID__PC;
    logic              Need_Stall, Flush;
    logic              WB__R_WE;
    logic [REG_W-1:0]  WB__Rdst;
    logic [DATA_W-1:0] WB__Data;
    logic              IDex__Valid;
    logic [REG_W-1:0]  IDex__Rs1, IDex__Rs2, IDex__Rdst;
    logic              IDex__Need_Rs1, IDex__Need_Rs2;
    logic              IDex__R_WE, IDex__Read_MEM, IDex__Write_MEM;
    logic [1:0]        IDex__RDst_S;
    logic [3:0]        IDex__ALU_Op;
    logic [DATA_W-1:0] IDex__Op1, IDex__Op2, IDex__Imm, IDex__PC;
    logic [CNT_W-1:0]  Stall_Cnt, Bubble_Cnt;

    modport master (
        output ID__Valid, ID__Rs1, ID__Rs2, ID__Rdst, ID__Need_Rs1, ID__Need_Rs2,
               ID__R_WE, ID__Read_MEM, ID__Write_MEM, ID__RDst_S, ID__ALU_Op,
               ID__Op1, ID__Op2, ID__Imm, ID__PC, Need_Stall, Flush,
               WB__R_WE, WB__Rdst, WB__Data,
        input  IDex__Valid, IDex__Rs1, IDex__Rs2, IDex__Rdst, IDex__Need_Rs1, IDex__Need_Rs2,
               IDex__R_WE, IDex__Read_MEM, IDex__Write_MEM, IDex__RDst_S, IDex__ALU_Op,
               IDex__Op1, IDex__Op2, IDex__Imm, IDex__PC, Stall_Cnt, Bubble_Cnt
    );

    modport slave (
        input  ID__Valid, ID__Rs1, ID__Rs2, ID__Rdst, ID__Need_Rs1, ID__Need_Rs2,
               ID__R_WE, ID__Read_MEM, ID__Write_MEM, ID__RDst_S, ID__ALU_Op,
               ID__Op1, ID__Op2, ID__Imm, ID__PC, Need_Stall, Flush,
               WB__R_WE, WB__Rdst, WB__Data,
        output IDex__Valid, IDex__Rs1, IDex__Rs2, IDex__Rdst, IDex__Need_Rs1, IDex__Need_Rs2,
               IDex__R_WE, IDex__Read_MEM, IDex__Write_MEM, IDex__RDst_S, IDex__ALU_Op,
               IDex__Op1, IDex__Op2, IDex__Imm, IDex__PC, Stall_Cnt, Bubble_Cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall hold, bubble insertion and write-back operand refresh
module id_ex_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16,
    parameter bit R0_ZERO = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    id_ex_reg_if.slave bus
);
    logic              hold, bubble;
    logic [REG_W-1:0]  sel_rs1, sel_rs2;
    logic              sel_need1, sel_need2, hit1, hit2;
    logic [DATA_W-1:0] nxt_op1, nxt_op2;
    logic [CNT_W-1:0]  stall_inc, bubble_inc;

    // Refresh compares against the held instruction while stalling, otherwise the incoming one
    always_comb begin
        hold       = bus.Need_Stall;
        bubble     = bus.Flush || !bus.ID__Valid;
        sel_rs1    = hold ? bus.IDex__Rs1 : bus.ID__Rs1;
        sel_rs2    = hold ? bus.IDex__Rs2 : bus.ID__Rs2;
        sel_need1  = hold ? bus.IDex__Need_Rs1 : bus.ID__Need_Rs1;
        sel_need2  = hold ? bus.IDex__Need_Rs2 : bus.ID__Need_Rs2;
        hit1       = bus.WB__R_WE && sel_need1 && (bus.WB__Rdst == sel_rs1) && !(R0_ZERO && sel_rs1 == '0);
        hit2       = bus.WB__R_WE && sel_need2 && (bus.WB__Rdst == sel_rs2) && !(R0_ZERO && sel_rs2 == '0);
        nxt_op1    = hit1 ? bus.WB__Data : (hold ? bus.IDex__Op1 : bus.ID__Op1);
        nxt_op2    = hit2 ? bus.WB__Data : (hold ? bus.IDex__Op2 : bus.ID__Op2);
        stall_inc  = bus.Stall_Cnt + CNT_W'(bus.Stall_Cnt != '1);
        bubble_inc = bus.Bubble_Cnt + CNT_W'(bus.Bubble_Cnt != '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.IDex__Valid     <= 1'b0;
            bus.IDex__Rs1       <= '0;
            bus.IDex__Rs2       <= '0;
            bus.IDex__Rdst      <= '0;
            bus.IDex__Need_Rs1  <= 1'b0;
            bus.IDex__Need_Rs2  <= 1'b0;
            bus.IDex__R_WE      <= 1'b0;
            bus.IDex__Read_MEM  <= 1'b0;
            bus.IDex__Write_MEM <= 1'b0;
            bus.IDex__RDst_S    <= 2'b00;
            bus.IDex__ALU_Op    <= '0;
            bus.IDex__Op1       <= '0;
            bus.IDex__Op2       <= '0;
            bus.IDex__Imm       <= '0;
            bus.IDex__PC        <= '0;
            bus.Stall_Cnt       <= '0;
            bus.Bubble_Cnt      <= '0;
        end else if (hold) begin
            bus.IDex__Op1 <= nxt_op1;
            bus.IDex__Op2 <= nxt_op2;
            if (bus.IDex__Valid) bus.Stall_Cnt <= stall_inc;
        end else if (bubble) begin
            bus.IDex__Valid     <= 1'b0;
            bus.IDex__Rs1       <= '0;
            bus.IDex__Rs2       <= '0;
            bus.IDex__Rdst      <= '0;
            bus.IDex__Need_Rs1  <= 1'b0;
            bus.IDex__Need_Rs2  <= 1'b0;
            bus.IDex__R_WE      <= 1'b0;
            bus.IDex__Read_MEM  <= 1'b0;
            bus.IDex__Write_MEM <= 1'b0;
            bus.IDex__RDst_S    <= 2'b00;
            bus.IDex__ALU_Op    <= '0;
            bus.IDex__Op1       <= '0;
            bus.IDex__Op2       <= '0;
            bus.IDex__Imm       <= '0;
            bus.IDex__PC        <= '0;
            bus.Bubble_Cnt      <= bubble_inc;
        end else begin
            bus.IDex__Valid     <= 1'b1;
            bus.IDex__Rs1       <= bus.ID__Rs1;
            bus.IDex__Rs2       <= bus.ID__Rs2;
            bus.IDex__Rdst      <= bus.ID__Rdst;
            bus.IDex__Need_Rs1  <= bus.ID__Need_Rs1;
            bus.IDex__Need_Rs2  <= bus.ID__Need_Rs2;
            bus.IDex__R_WE      <= bus.ID__R_WE;
            bus.IDex__Read_MEM  <= bus.ID__Read_MEM;
            bus.IDex__Write_MEM <= bus.ID__Write_MEM;
            bus.IDex__RDst_S    <= bus.ID__RDst_S;
            bus.IDex__ALU_Op    <= bus.ID__ALU_Op;
            bus.IDex__Op1       <= nxt_op1;
            bus.IDex__Op2       <= nxt_op2;
            bus.IDex__Imm       <= bus.ID__Imm;
            bus.IDex__PC        <= bus.ID__PC;
        end
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed scoreboard bench for the ID/EX pipeline register
module tb_id_ex_reg;
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rdst;
        logic        n1, n2, we, rm, wm;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [31:0] op1, op2, imm, pc;
        logic [15:0] scnt, bcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t e;
    exp_t q_e[$];
    string q_n[$];

    id_ex_reg_if bus ();
    id_ex_reg dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t act();
        exp_t r;
        r.valid = bus.IDex__Valid;     r.rs1 = bus.IDex__Rs1;        r.rs2 = bus.IDex__Rs2;
        r.rdst  = bus.IDex__Rdst;      r.n1  = bus.IDex__Need_Rs1;   r.n2  = bus.IDex__Need_Rs2;
        r.we    = bus.IDex__R_WE;      r.rm  = bus.IDex__Read_MEM;   r.wm  = bus.IDex__Write_MEM;
        r.rs    = bus.IDex__RDst_S;    r.alu = bus.IDex__ALU_Op;     r.op1 = bus.IDex__Op1;
        r.op2   = bus.IDex__Op2;       r.imm = bus.IDex__Imm;        r.pc  = bus.IDex__PC;
        r.scnt  = bus.Stall_Cnt;       r.bcnt = bus.Bubble_Cnt;
        return r;
    endfunction

    // Expected image of a plain load of the current ID inputs; counters carried from e
    function automatic exp_t ld();
        exp_t r;
        r.valid = 1'b1;                r.rs1 = bus.ID__Rs1;          r.rs2 = bus.ID__Rs2;
        r.rdst  = bus.ID__Rdst;        r.n1  = bus.ID__Need_Rs1;     r.n2  = bus.ID__Need_Rs2;
        r.we    = bus.ID__R_WE;        r.rm  = bus.ID__Read_MEM;     r.wm  = bus.ID__Write_MEM;
        r.rs    = bus.ID__RDst_S;      r.alu = bus.ID__ALU_Op;       r.op1 = bus.ID__Op1;
        r.op2   = bus.ID__Op2;         r.imm = bus.ID__Imm;          r.pc  = bus.ID__PC;
        r.scnt  = e.scnt;              r.bcnt = e.bcnt;
        return r;
    endfunction

    function automatic exp_t bub();
        exp_t r;
        r = '0;
        r.scnt = e.scnt;
        r.bcnt = e.bcnt + 16'd1;
        return r;
    endfunction

    task automatic set_id(input logic [4:0] rs1, rs2, rdst, input logic n1, n2, we, rm, wm,
                          input logic [1:0] rs, input logic [3:0] alu,
                          input logic [31:0] op1, op2, imm, pc);
        bus.ID__Valid = 1'b1;   bus.ID__Rs1 = rs1;       bus.ID__Rs2 = rs2;     bus.ID__Rdst = rdst;
        bus.ID__Need_Rs1 = n1;  bus.ID__Need_Rs2 = n2;   bus.ID__R_WE = we;     bus.ID__Read_MEM = rm;
        bus.ID__Write_MEM = wm; bus.ID__RDst_S = rs;     bus.ID__ALU_Op = alu;
        bus.ID__Op1 = op1;      bus.ID__Op2 = op2;       bus.ID__Imm = imm;     bus.ID__PC = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.WB__R_WE = we;
        bus.WB__Rdst = rd;
        bus.WB__Data = d;
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        q_e.push_back(e);
        q_n.push_back(name);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        exp_t a;
        a = act();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s: got=%h exp=0", name, a);
        end
    endtask

    always @(negedge clk) begin
        if (q_e.size() != 0) begin
            exp_t x, a;
            string n;
            x = q_e.pop_front();
            n = q_n.pop_front();
            a = act();
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL %s: got=%h exp=%h", n, a, x);
            end
        end
    end

    always @(posedge clk)
        if (rst_n && bus.Flush && bus.Need_Stall)
            $display("note: Flush overlaps Need_Stall at %0t; flush ignored by design", $time);

    initial begin
        set_id(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.ID__Valid = 1'b0;
        bus.Need_Stall = 1'b0;
        bus.Flush = 1'b0;
        wb(0, 5'd0, 32'h0);
        e = '0;
        #1 rst_n = 1'b0;
        #2 chk_zero("reset_state");
        set_id(5'd3, 5'd4, 5'd5, 1, 0, 1, 0, 0, 2'b01, 4'h2, 32'h11, 32'h22, 32'h100, 32'h1000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e = ld();
        tick("load_basic");
        // Stall two edges while ID moves underneath
        bus.Need_Stall = 1'b1;
        set_id(5'd6, 5'd7, 5'd8, 1, 1, 1, 1, 0, 2'b00, 4'h3, 32'h33, 32'h44, 32'h8, 32'h1004);
        e.scnt = 16'd1;
        tick("stall_1");
        bus.ID__PC = 32'h1008;
        bus.ID__Op1 = 32'h55;
        e.scnt = 16'd2;
        tick("stall_2");
        bus.Need_Stall = 1'b0;
        e = ld();
        tick("load_after_stall");
        bus.Need_Stall = 1'b1;
        wb(1, 5'd7, 32'hABCD);
        e.op2 = 32'hABCD;
        e.scnt = 16'd3;
        tick("hold_refresh_op2");
        bus.Need_Stall = 1'b0;
        wb(0, 5'd0, 32'h0);
        set_id(5'd9, 5'd0, 5'd1, 0, 1, 0, 0, 1, 2'b10, 4'h5, 32'h66, 32'h77, 32'h4, 32'h100C);
        e = ld();
        tick("load_rs2_zero");
        bus.Need_Stall = 1'b1;
        wb(1, 5'd0, 32'hDEAD);
        e.scnt = 16'd4;
        tick("hold_r0_no_refresh");
        bus.Need_Stall = 1'b0;
        set_id(5'd10, 5'd11, 5'd12, 1, 0, 0, 0, 1, 2'b11, 4'h7, 32'h5, 32'h6, 32'hFFFF_FFF0, 32'h2000);
        wb(1, 5'd10, 32'h9);
        e = ld();
        e.op1 = 32'h9;
        tick("load_fwd_op1");
        bus.ID__Need_Rs1 = 1'b0;
        e = ld();
        tick("load_no_need_rs1");
        bus.ID__Need_Rs2 = 1'b1;
        wb(1, 5'd11, 32'h99);
        e = ld();
        e.op2 = 32'h99;
        tick("load_fwd_op2");
        wb(0, 5'd11, 32'h99);
        e = ld();
        tick("load_wb_disabled");
        bus.Flush = 1'b1;
        e = bub();
        tick("flush_bubble");
        bus.Flush = 1'b0;
        bus.ID__Valid = 1'b0;
        bus.ID__Need_Rs1 = 1'b1;
        wb(1, 5'd10, 32'h1234);
        e = bub();
        tick("invalid_bubble");
        wb(0, 5'd0, 32'h0);
        set_id(5'd2, 5'd3, 5'd4, 1, 1, 1, 0, 0, 2'b01, 4'h1, 32'hA, 32'hB, 32'hC, 32'h3000);
        e = ld();
        tick("reload");
        bus.Flush = 1'b1;
        bus.Need_Stall = 1'b1;
        e.scnt = e.scnt + 16'd1;
        tick("flush_during_stall");
        bus.Flush = 1'b0;
        while (e.scnt != 16'hFFFE) begin
            e.scnt = e.scnt + 16'd1;
            tick("stall_run");
        end
        e.scnt = 16'hFFFF;
        repeat (3) tick("stall_saturate");
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_mid_stall");
        @(negedge clk);
        rst_n = 1'b1;
        e = '0;
        tick("stall_after_reset");
        bus.Need_Stall = 1'b0;
        e = ld();
        tick("load_after_reset");
        for (int i = 0; i < 4 && q_e.size() != 0; i++) @(negedge clk);
        if (q_e.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending exp=0", q_e.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
